// File: rtl/mem_stream_pkg.sv
// rtl/mem_stream_pkg.sv - shared types and constants for the entry-memory stream reader
package mem_stream_pkg;

  localparam int PTR_W  = 16;
  localparam int DATA_W = 128;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  index;
    logic              last;
  } entry_t;

  // Modulo increment; the modulus need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr,
                                                input int unsigned      modulus);
    return (32'(ptr) == modulus - 1) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// rtl/mem_stream_reader_fifo.sv - first-word-fall-through skid FIFO carrying entry_t
module stream_fifo
  import mem_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output entry_t                       head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            do_pop, full;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    valid_o = (cnt_q != '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop_i && valid_o;
    count_o = cnt_q;
    // Empty head reads as zero so stale entries never leak onto the outputs.
    head_o  = valid_o ? mem_q[rd_q] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  // The reader's credit check must make an unpopped push into a full FIFO impossible.
  assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !do_pop));

endmodule

// File: rtl/mem_stream_reader.sv
// rtl/mem_stream_reader.sv - walks count entries from base_ptr and streams them through a skid FIFO
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int DEPTH   = 4,
  parameter int DW      = DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PTR_W-1:0] base_ptr,
  input  logic [PTR_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [PTR_W-1:0] rd_ptr,
  output logic             rd_en,
  input  logic             mem_wen,
  input  logic [DW-1:0]    mem_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [PTR_W-1:0] out_index,
  output logic             out_last
);

  localparam int FCW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] issue_ptr_q, issue_ptr_d;
  logic [PTR_W-1:0] issued_q, issued_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] cap_index_q;
  logic             cap_last_q;
  logic             inflight_q;

  logic             credit_ok, issue, accept, last_issue, pop, last_hs;
  logic             fifo_valid;
  logic [FCW-1:0]   fifo_count;
  entry_t           push_entry, head;

  always_comb begin
    // A pending capture already owns a FIFO slot, so it counts against credit.
    credit_ok  = (32'(fifo_count) + 32'(inflight_q)) < 32'(DEPTH);
    issue      = (state_q == ST_RUN) && (issued_q < count_q) && credit_ok;
    accept     = issue && !mem_wen;
    last_issue = (issued_q == count_q - PTR_W'(1));
    pop        = fifo_valid && out_ready;
    last_hs    = pop && head.last;

    state_d     = state_q;
    issue_ptr_d = issue_ptr_q;
    issued_d    = issued_q;
    count_d     = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d     = count;
          issue_ptr_d = base_ptr;
          issued_d    = '0;
          state_d     = (count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // A read colliding with a write is dropped; the same index is retried.
        if (accept) begin
          issue_ptr_d = wrap_inc(issue_ptr_q, ENTRIES);
          issued_d    = issued_q + PTR_W'(1);
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_hs && (fifo_count == FCW'(1)) && !inflight_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      issue_ptr_q <= '0;
      issued_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      cap_index_q <= '0;
      cap_last_q  <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_ptr_q <= issue_ptr_d;
      issued_q    <= issued_d;
      count_q     <= count_d;
      inflight_q  <= accept;
      if (accept) begin
        cap_index_q <= issue_ptr_q;
        cap_last_q  <= last_issue;
      end
      if (issue) rd_ptr_q <= issue_ptr_q;
    end
  end

  always_comb begin
    busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done       = (state_q == ST_DONE);
    rd_en      = issue;
    rd_ptr     = issue ? issue_ptr_q : rd_ptr_q;
    push_entry = '{data: DATA_W'(mem_data), index: cap_index_q, last: cap_last_q};
    out_valid  = fifo_valid;
    out_data   = DW'(head.data);
    out_index  = head.index;
    out_last   = head.last;
  end

  stream_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (inflight_q),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .valid_o    (fifo_valid),
    .head_o     (head),
    .count_o    (fifo_count)
  );

endmodule
